// File: rtl/qtpa_pkg.sv
// Shared instruction-queue constants: instruction width and the bubble encoding.
package qtpa_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_ENC = 32'h0000_0000;

endpackage

// File: rtl/qtps_iq_mem.sv
// Instruction storage: DEPTH x INSTR_WIDTH register array.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none here; the owner gates the write enable.
module qtps_iq_mem
  import qtpa_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qtps_iq.sv
// Instruction queue feeding a registered instruction word to core decode.
// Latency: 2 edges from push into an empty queue to instruction, no bypass.
// Backpressure: in_ready drops only when full; stall freezes the output register.
module qtps_iq
  import qtpa_pkg::*;
#(
  parameter int                     DEPTH    = 8,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSN = NOP_ENC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  output logic                     in_ready,
  input  logic                     stall,
  input  logic                     flush,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              bubble_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [INSTR_WIDTH-1:0] head_dat;

  assign full     = (count == CW'(DEPTH));
  // Ready ignores stall and any same-cycle pop so it never depends on the core.
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !stall && !flush && (count != '0);

  qtps_iq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata (in_instr),
    .raddr (head),
    .rdata (head_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      instruction <= NOP_INSN;
      issue_valid <= 1'b0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      instruction <= NOP_INSN;
      issue_valid <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (!stall) begin
        if (pop) begin
          instruction <= head_dat;
          issue_valid <= 1'b1;
        end else begin
          instruction <= NOP_INSN;
          issue_valid <= 1'b0;
          if (bubble_cnt != 16'hFFFF) begin
            bubble_cnt <= bubble_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qtps_iq.sv
// Self-checking bench for qtps_iq: directed vector table plus a FIFO scoreboard.
module tb_qtps_iq;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic [31:0] instruction;
  logic        issue_valid;
  logic [3:0]  count;
  logic [15:0] bubble_cnt;

  qtps_iq #(.DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .count       (count),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_instr;
  logic        exp_iv;
  logic [15:0] exp_bub;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        s;
    logic        f;
    logic        r;
    logic [31:0] e_instr;
    logic        e_iv;
    int          e_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given inputs; scoreboard checks follow the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic s,
                      input logic f, input logic r);
    logic pre_ready;
    logic accepted;
    in_valid = v;
    in_instr = d;
    stall    = s;
    flush    = f;
    rst      = r;
    #1;
    pre_ready = in_ready;
    check("in_ready", {31'd0, pre_ready}, {31'd0, (!r && exp_q.size() < DEPTH)});
    accepted = v && !r && (exp_q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      exp_instr = NOP;
      exp_iv    = 1'b0;
      exp_bub   = 16'd0;
    end else if (f) begin
      exp_q.delete();
      exp_instr = NOP;
      exp_iv    = 1'b0;
    end else begin
      if (!s) begin
        if (exp_q.size() > 0) begin
          exp_instr = exp_q.pop_front();
          exp_iv    = 1'b1;
        end else begin
          exp_instr = NOP;
          exp_iv    = 1'b0;
          if (exp_bub != 16'hFFFF) exp_bub = exp_bub + 16'd1;
        end
      end
      if (accepted) exp_q.push_back(d);
    end
    check("instruction", instruction, exp_instr);
    check("issue_valid", {31'd0, issue_valid}, {31'd0, exp_iv});
    check("count", {28'd0, count}, exp_q.size());
    check("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, exp_bub});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_instr = NOP;
    exp_iv    = 1'b0;
    exp_bub   = 16'd0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    stall     = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;

    // Reset, then A1/A2 back to back: A1 two edges after its push, then A2, then a bubble.
    vecs[0] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, NOP,   1'b0, 0};
    vecs[1] = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, NOP,   1'b0, 1};
    vecs[2] = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 32'hA1, 1'b1, 1};
    vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'hA2, 1'b1, 0};
    vecs[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, NOP,   1'b0, 0};
    vecs[5] = '{1'b1, 32'hB7, 1'b1, 1'b0, 1'b0, NOP,   1'b0, 1};
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].f, vecs[i].r);
      check($sformatf("vec%0d_instr", i), instruction, vecs[i].e_instr);
      check($sformatf("vec%0d_iv", i), {31'd0, issue_valid}, {31'd0, vecs[i].e_iv});
      check($sformatf("vec%0d_count", i), {28'd0, count}, vecs[i].e_cnt);
    end
    idle(3);

    // Fill while stalled: 8 accepted, 9th refused, then drain in order and bubble.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 32'hC000_0000 + i, 1'b1, 1'b0, 1'b0);
    check("full_count", {28'd0, count}, 32'd8);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    check("ninth_dropped", {28'd0, count}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("drain_order", instruction, 32'hC000_0000 + i);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("drain_bubble", {31'd0, issue_valid}, 32'd0);

    // Push+pop at count=DEPTH-1 keeps count.
    for (int i = 0; i < 7; i++) step(1'b1, 32'hE000_0000 + i, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hE000_0007, 1'b0, 1'b0, 1'b0);
    check("pp_at_7", {28'd0, count}, 32'd7);
    idle(8);

    // 20 continuous push/pop pairs at count=3: constant count, wraps twice, no bubbles.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5500_0000 + i, 1'b1, 1'b0, 1'b0);
    begin
      logic [15:0] bub_before;
      bub_before = bubble_cnt;
      for (int i = 3; i < 23; i++) begin
        step(1'b1, 32'h5500_0000 + i, 1'b0, 1'b0, 1'b0);
        check("pair_count", {28'd0, count}, 32'd3);
        check("pair_order", instruction, 32'h5500_0000 + i - 3);
      end
      check("pair_no_bubble", {16'd0, bubble_cnt}, {16'd0, bub_before});
    end
    idle(4);

    // Flush at count=5 together with a push and a stall.
    for (int i = 0; i < 5; i++) step(1'b1, 32'hF100_0000 + i, 1'b1, 1'b0, 1'b0);
    check("pre_flush_count", {28'd0, count}, 32'd5);
    step(1'b1, 32'hF1FF_FFFF, 1'b1, 1'b1, 1'b0);
    check("flush_count", {28'd0, count}, 32'd0);
    check("flush_iv", {31'd0, issue_valid}, 32'd0);
    check("flush_instr", instruction, NOP);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("flush_lost_push", {31'd0, issue_valid}, 32'd0);

    // Reset mid-stream at count=3.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h7700_0000 + i, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h7777_7777, 1'b0, 1'b1, 1'b1);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_bub", {16'd0, bubble_cnt}, 32'd0);
    check("rst_instr", instruction, NOP);
    step(1'b1, 32'h8800_0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("post_rst_latency", instruction, 32'h8800_0001);

    // Bubble counter saturation.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(65534);
    check("bub_fffe", {16'd0, bubble_cnt}, 32'h0000_FFFE);
    idle(3);
    check("bub_sat", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("bub_hold", {16'd0, bubble_cnt}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
